// File: rtl/qpsk_link_sequencer_pkg.sv
// Shared types for the QPSK link bring-up sequencer: FSM state encoding,
// failure cause codes and the counter sizing helper.
package qpsk_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_WAIT_SYNC,
        ST_OBSERVE,
        ST_PASS,
        ST_FAIL
    } seq_state_t;

    localparam logic [1:0] FC_NONE         = 2'b00;
    localparam logic [1:0] FC_SYNC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_SYNC_LOST    = 2'b10;
    localparam logic [1:0] FC_BER_BAD      = 2'b11;

    // One shared phase counter must hold (bound-1) for the largest bound.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/qpsk_link_sequencer_if.sv
// Control/status bundle between the VIO/switch side, the sequencer and the
// comm system; master is the sequencer itself.
interface qpsk_link_sequencer_if;

    logic       i_start;
    logic       i_abort;
    logic       i_sync_done_i;
    logic       i_sync_done_q;
    logic       i_ber_ok_i;
    logic       i_ber_ok_q;
    logic       o_sys_rst_n;
    logic       o_sys_enable;
    logic       o_busy;
    logic       o_pass;
    logic       o_fail;
    logic [1:0] o_fail_code;
    logic [3:0] o_retry_cnt;

    modport master (
        input  i_start, i_abort, i_sync_done_i, i_sync_done_q, i_ber_ok_i, i_ber_ok_q,
        output o_sys_rst_n, o_sys_enable, o_busy, o_pass, o_fail, o_fail_code, o_retry_cnt
    );

    modport slave (
        output i_start, i_abort, i_sync_done_i, i_sync_done_q, i_ber_ok_i, i_ber_ok_q,
        input  o_sys_rst_n, o_sys_enable, o_busy, o_pass, o_fail, o_fail_code, o_retry_cnt
    );

endinterface

// File: rtl/qpsk_link_sequencer_sync_rise_det.sv
// Two-flop synchroniser for an asynchronous level input followed by a
// registered single-cycle rising-edge pulse.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    // [0],[1] are the synchroniser stages, [2] holds the previous synced value
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
            pulse  <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/qpsk_link_sequencer.sv
// Bring-up/self-test sequencer for the QPSK comm system: reset, enable,
// wait for I/Q sync, observe BER, report pass/fail with bounded retries.
module qpsk_link_sequencer
    import qpsk_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned SYNC_TIMEOUT = 1_000_000,
    parameter int unsigned OBS_CYCLES   = 65536,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                 clk,
    input  logic                 i_reset,
    qpsk_link_sequencer_if.master bus
);

    localparam int unsigned      CNT_W     = cnt_width(RST_CYCLES, SYNC_TIMEOUT, OBS_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] OBS_LAST  = CNT_W'(OBS_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [1:0]       code_q, code_d, fail_cause;
    logic             pass_q, pass_d, fail_q, fail_d, fail_evt;
    logic             sys_rst_n_q, sys_en_q, busy_q;
    logic             sync_i_q, sync_q_q, ber_i_q, ber_q_q;
    logic             start_pulse;

    sync_rise_det u_start_det (
        .clk      (clk),
        .rst_n    (i_reset),
        .async_in (bus.i_start),
        .pulse    (start_pulse)
    );

    // Comm status is registered once; decisions act one edge after the sample.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            code_q      <= FC_NONE;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            sys_rst_n_q <= 1'b0;
            sys_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            sync_i_q    <= 1'b0;
            sync_q_q    <= 1'b0;
            ber_i_q     <= 1'b0;
            ber_q_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            code_q      <= code_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            sys_rst_n_q <= (state_d != ST_RESET);
            sys_en_q    <= (state_d inside {ST_WAIT_SYNC, ST_OBSERVE, ST_PASS});
            busy_q      <= (state_d inside {ST_RESET, ST_WAIT_SYNC, ST_OBSERVE});
            sync_i_q    <= bus.i_sync_done_i;
            sync_q_q    <= bus.i_sync_done_q;
            ber_i_q     <= bus.i_ber_ok_i;
            ber_q_q     <= bus.i_ber_ok_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        retry_d    = retry_q;
        code_d     = code_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        fail_evt   = 1'b0;
        fail_cause = FC_NONE;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start_pulse) begin
                    state_d = ST_RESET;
                    retry_d = '0;
                    code_d  = FC_NONE;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            ST_RESET: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) state_d = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                cnt_d = cnt_q + 1'b1;
                if (sync_i_q && sync_q_q) begin
                    state_d = ST_OBSERVE;
                end else if (cnt_q == SYNC_LAST) begin
                    fail_evt   = 1'b1;
                    fail_cause = FC_SYNC_TIMEOUT;
                end
            end
            ST_OBSERVE: begin
                cnt_d = cnt_q + 1'b1;
                if (!sync_i_q || !sync_q_q) begin
                    fail_evt   = 1'b1;
                    fail_cause = FC_SYNC_LOST;
                end else if (!ber_i_q || !ber_q_q) begin
                    fail_evt   = 1'b1;
                    fail_cause = FC_BER_BAD;
                end else if (cnt_q == OBS_LAST) begin
                    state_d = ST_PASS;
                    pass_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail_evt) begin
            code_d = fail_cause;
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_RESET;
            end else begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
            end
        end

        if (bus.i_abort) begin
            state_d = ST_IDLE;
            retry_d = '0;
            code_d  = FC_NONE;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end

        // A retry re-enters RESET from another state, so this covers every entry.
        if (state_d != state_q) cnt_d = '0;
    end

    assign bus.o_sys_rst_n  = sys_rst_n_q;
    assign bus.o_sys_enable = sys_en_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_pass       = pass_q;
    assign bus.o_fail       = fail_q;
    assign bus.o_fail_code  = code_q;
    assign bus.o_retry_cnt  = retry_q;

endmodule

// File: tb/tb_qpsk_link_sequencer.sv
// Self-checking bench for qpsk_link_sequencer: scripted comm-system stimulus,
// expected run outcomes queued at start and compared when the run ends.
module tb_qpsk_link_sequencer;
    import qpsk_seq_pkg::*;

    localparam int unsigned RST_N    = 4;
    localparam int unsigned SYNC_TO  = 20;
    localparam int unsigned OBS_N    = 10;
    localparam int unsigned RETRIES  = 2;
    localparam int unsigned TO_BOUND = 2000;

    logic clk = 1'b0;
    logic i_reset;

    qpsk_link_sequencer_if bus ();

    qpsk_link_sequencer #(
        .RST_CYCLES   (RST_N),
        .SYNC_TIMEOUT (SYNC_TO),
        .OBS_CYCLES   (OBS_N),
        .MAX_RETRIES  (RETRIES)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pass;
        logic       fail;
        logic [1:0] code;
        logic [3:0] retry;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t mk_exp(input logic p, input logic f, input logic [1:0] c,
                                    input logic [3:0] r);
        exp_t e;
        e.pass = p; e.fail = f; e.code = c; e.retry = r;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sync(input logic v);
        bus.i_sync_done_i = v;
        bus.i_sync_done_q = v;
    endtask

    task automatic check_idle(input string tag, input logic rst_n_exp);
        check_eq({tag, "_rst_n"},  bus.o_sys_rst_n,  rst_n_exp);
        check_eq({tag, "_enable"}, bus.o_sys_enable, 0);
        check_eq({tag, "_busy"},   bus.o_busy,       0);
        check_eq({tag, "_pass"},   bus.o_pass,       0);
        check_eq({tag, "_fail"},   bus.o_fail,       0);
        check_eq({tag, "_code"},   bus.o_fail_code,  FC_NONE);
        check_eq({tag, "_retry"},  bus.o_retry_cnt,  0);
    endtask

    // i_start first sampled at edge n must drive o_sys_rst_n low after edge n+3.
    task automatic start_run(input string tag);
        set_sync(1'b0);
        bus.i_start = 1'b1;
        repeat (3) tick();
        check_eq({tag, "_start_lat_pre"}, bus.o_sys_rst_n, 1);
        tick();
        check_eq({tag, "_start_lat"}, bus.o_sys_rst_n, 0);
        bus.i_start = 1'b0;
    endtask

    task automatic count_low(output int unsigned n);
        n = 0;
        while (bus.o_sys_rst_n === 1'b0 && n < TO_BOUND) begin
            n++;
            tick();
        end
    endtask

    task automatic count_wait(output int unsigned n);
        n = 0;
        while (bus.o_sys_enable === 1'b1 && bus.o_sys_rst_n === 1'b1 && n < TO_BOUND) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_result(input string tag);
        exp_t        e;
        int unsigned n = 0;
        while (!(bus.o_pass === 1'b1 || bus.o_fail === 1'b1) && n < TO_BOUND) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, bus.o_pass | bus.o_fail, 1);
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_nonempty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_pass"},   bus.o_pass,       e.pass);
            check_eq({tag, "_fail"},   bus.o_fail,       e.fail);
            check_eq({tag, "_code"},   bus.o_fail_code,  e.code);
            check_eq({tag, "_retry"},  bus.o_retry_cnt,  e.retry);
            check_eq({tag, "_enable"}, bus.o_sys_enable, e.pass);
            check_eq({tag, "_busy"},   bus.o_busy,       0);
        end
    endtask

    // Syncs set just after WAIT entry edge w are sampled at w+1, OBSERVE at w+2,
    // PASS OBS_N edges later: 2 + OBS_N ticks in total.
    task automatic pass_after_sync(input string tag);
        int unsigned n = 0;
        set_sync(1'b1);
        while (bus.o_pass !== 1'b1 && n < TO_BOUND) begin
            tick();
            n++;
        end
        check_eq({tag, "_sync_to_pass"}, n, 2 + OBS_N);
        wait_result(tag);
    endtask

    task automatic clean_run(input string tag);
        int unsigned n;
        sb.push_back(mk_exp(1'b1, 1'b0, FC_NONE, 4'd0));
        start_run(tag);
        count_low(n);
        check_eq({tag, "_rst_len"}, n, RST_N);
        check_eq({tag, "_wait_enable"}, bus.o_sys_enable, 1);
        check_eq({tag, "_wait_busy"},   bus.o_busy, 1);
        repeat (5) tick();
        check_eq({tag, "_no_early_pass"}, bus.o_pass, 0);
        bus.i_sync_done_i = 1'b1;
        bus.i_sync_done_q = 1'b1;
        pass_after_sync(tag);
    endtask

    // Drop sync (optionally with BER) at OBSERVE cycle 3 on the first attempt.
    task automatic drop_run(input string tag, input logic ber_too);
        int unsigned n;
        sb.push_back(mk_exp(1'b1, 1'b0, FC_SYNC_LOST, 4'd1));
        start_run(tag);
        count_low(n);
        check_eq({tag, "_rst_len"}, n, RST_N);
        set_sync(1'b1);
        repeat (5) tick();
        if (ber_too) begin
            bus.i_sync_done_i = 1'b0;
            bus.i_ber_ok_i    = 1'b0;
        end else begin
            bus.i_sync_done_q = 1'b0;
        end
        tick();
        check_eq({tag, "_pre_retry"}, bus.o_sys_rst_n, 1);
        tick();
        check_eq({tag, "_retry_edge"},  bus.o_sys_rst_n, 0);
        check_eq({tag, "_retry_code"},  bus.o_fail_code, FC_SYNC_LOST);
        check_eq({tag, "_retry_cnt"},   bus.o_retry_cnt, 1);
        set_sync(1'b0);
        bus.i_ber_ok_i = 1'b1;
        count_low(n);
        check_eq({tag, "_rst_len2"}, n, RST_N);
        pass_after_sync(tag);
    endtask

    initial begin
        int unsigned n;
        int unsigned lows;

        i_reset           = 1'b0;
        bus.i_start       = 1'b0;
        bus.i_abort       = 1'b0;
        bus.i_ber_ok_i    = 1'b1;
        bus.i_ber_ok_q    = 1'b1;
        set_sync(1'b0);

        repeat (3) tick();
        check_idle("por", 1'b0);
        i_reset = 1'b1;
        tick();
        check_idle("por_rel", 1'b1);

        clean_run("clean");

        sb.push_back(mk_exp(1'b0, 1'b1, FC_SYNC_TIMEOUT, 4'd2));
        start_run("nosync");
        for (int unsigned a = 0; a <= RETRIES; a++) begin
            count_low(n);
            check_eq($sformatf("nosync_rst_len%0d", a), n, RST_N);
            check_eq($sformatf("nosync_retry%0d", a), bus.o_retry_cnt, a);
            check_eq($sformatf("nosync_code%0d", a), bus.o_fail_code,
                     (a == 0) ? FC_NONE : FC_SYNC_TIMEOUT);
            count_wait(n);
            check_eq($sformatf("nosync_wait_len%0d", a), n, SYNC_TO);
        end
        wait_result("nosync");

        drop_run("lost_q", 1'b0);
        drop_run("lost_and_ber", 1'b1);

        // Abort in the second WAIT_SYNC, after a retry has set code and count.
        start_run("abort");
        count_low(n);
        count_wait(n);
        count_low(n);
        check_eq("abort_pre_retry", bus.o_retry_cnt, 1);
        bus.i_start = 1'b1;
        lows = 0;
        repeat (6) begin
            tick();
            if (bus.o_sys_rst_n !== 1'b1) lows++;
        end
        check_eq("busy_start_ignored", lows, 0);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b1;
        tick();
        check_idle("abort", 1'b1);
        bus.i_abort = 1'b0;
        clean_run("after_abort");

        start_run("midreset");
        count_low(n);
        set_sync(1'b1);
        repeat (5) tick();
        check_eq("midreset_busy", bus.o_busy, 1);
        i_reset = 1'b0;
        tick();
        check_idle("midreset", 1'b0);
        i_reset = 1'b1;
        set_sync(1'b0);
        tick();
        check_idle("midreset_rel", 1'b1);
        clean_run("after_reset");

        check_eq("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qpsk_link_sequencer.md
# qpsk_link_sequencer

Bring-up and self-test controller for the QPSK communication system. On a start request it holds the comm system in reset, releases and enables it, and waits for I and Q synchronisation with a timeout. It then requires clean BER-ok status for an observation window and reports pass/fail with a cause code, retrying up to a limit. It sits between the VIO/physical controls and the comm system, replacing direct reset/switch drive.

## Interface
- `RST_CYCLES`, default 16: cycles `o_sys_rst_n` is held low per attempt, ≥1.
- `SYNC_TIMEOUT`, default 1_000_000: cycles allowed in WAIT_SYNC, ≥2.
- `OBS_CYCLES`, default 65536: consecutive good cycles required in OBSERVE, ≥1.
- `MAX_RETRIES`, default 3: extra attempts after the first failure, 0..15.
- `clk` in 1: system clock.
- `i_reset` in 1: reset. Synchronous, active-low.
- `i_start` in 1: start request from VIO or switch. Asynchronous to `clk`, level.
- `i_abort` in 1: abort to IDLE. Same domain as `clk`, level.
- `i_sync_done_i` in 1: I-branch sync done from comm system.
- `i_sync_done_q` in 1: Q-branch sync done from comm system.
- `i_ber_ok_i` in 1: I-branch BER ok.
- `i_ber_ok_q` in 1: Q-branch BER ok.
- `o_sys_rst_n` out 1: active-low reset to comm system.
- `o_sys_enable` out 1: drives comm system `i_sw`.
- `o_busy` out 1: high in RESET, WAIT_SYNC and OBSERVE.
- `o_pass` out 1: sticky pass.
- `o_fail` out 1: sticky fail.
- `o_fail_code` out 2: last failure cause. 00 none, 01 sync timeout, 10 sync lost, 11 BER bad.
- `o_retry_cnt` out 4: retries consumed in the current run.

## Operation
- **Start path.** `i_start` passes through a 2-flop synchroniser, then a rising-edge detector. The resulting `start_pulse` lasts 1 cycle.
- **IDLE.** `o_sys_rst_n`=1, `o_sys_enable`=0. On `start_pulse`, clear pass, fail, code and retry count, then go to RESET.
- **RESET.** `o_sys_rst_n`=0 and `o_sys_enable`=0 for exactly `RST_CYCLES` cycles, then go to WAIT_SYNC.
- **WAIT_SYNC.** `o_sys_rst_n`=1, `o_sys_enable`=1. A counter runs from 0.
  - Both syncs sampled high: go to OBSERVE.
  - Otherwise, counter reaches `SYNC_TIMEOUT-1`: failure event, code 01.
  - Sync success takes priority over timeout in the same cycle.
- **OBSERVE.** Enables held. A counter runs from 0.
  - Either sync low: failure, code 10. This takes priority.
  - Otherwise, either BER-ok low: failure, code 11.
  - Otherwise, counter reaches `OBS_CYCLES-1`: go to PASS.
- **Failure event.** Latch `o_fail_code`.
  - If `o_retry_cnt` < `MAX_RETRIES`: increment it, go to RESET.
  - Otherwise: go to FAIL.
- **PASS / FAIL.** Terminal and sticky. Enables stay as in OBSERVE in PASS. FAIL drives `o_sys_enable`=0 and `o_sys_rst_n`=1. A new `start_pulse` restarts as from IDLE. `o_fail_code` is kept in PASS after a retried failure.
- **Abort.** `i_abort` high in any state: next state IDLE, pass/fail/code/retry cleared. Abort beats `start_pulse`.
- **Start while busy.** `start_pulse` in RESET, WAIT_SYNC or OBSERVE is ignored.
- **Counter widths.** `$clog2` of the largest bound. Counters clear on every state entry.

## Timing
- **Registered outputs.** All outputs come from flops. Output values change on the same edge the state changes.
- **Reset values.** State IDLE. `o_sys_rst_n`=0 (comm system held in reset while the sequencer is in reset). `o_sys_enable`=0, `o_busy`=0, `o_pass`=0, `o_fail`=0, `o_fail_code`=00, `o_retry_cnt`=0. On the first cycle after reset release, `o_sys_rst_n`=1.
- **Start latency.** `i_start` first sampled high at edge n gives `o_sys_rst_n`=0 after edge n+3.
- **Sync latency.** Both syncs high sampled at edge m in WAIT_SYNC puts the state in OBSERVE after edge m+1.
- **Pass latency.** PASS is reached exactly `OBS_CYCLES` edges after OBSERVE entry when all inputs stay good.
- **Failure to retry.** `o_sys_rst_n` goes low on the edge after the failing sample.
- **Reset mid-operation.** Synchronous reset in any state restores the reset values on that edge, with no residual counts.

## Structure
- **Package `qpsk_seq_pkg`.** State encoding (IDLE, RESET, WAIT_SYNC, OBSERVE, PASS, FAIL) and the fail-code constants.
- **Sub-module `sync_rise_det`.** 2-flop synchroniser plus rising-edge pulse. Reused for other VIO/switch inputs.
- **Integration.** Instantiated in the VIO/ILA top. State and fail code go to ILA probes.

## Test plan
Bench parameters: `RST_CYCLES`=4, `SYNC_TIMEOUT`=20, `OBS_CYCLES`=10, `MAX_RETRIES`=2.

1. **Clean pass.** Start; raise both syncs 5 cycles after RESET exit; BER ok held high. Expect `o_sys_rst_n` low 4 cycles, OBSERVE 10 cycles, then `o_pass`=1, `o_fail_code`=00, `o_retry_cnt`=0.
2. **Sync never arrives.** Expect 3 attempts of 20 WAIT_SYNC cycles each, `o_retry_cnt`=2, `o_fail`=1, code 01.
3. **Sync lost mid-window.** Drop `i_sync_done_q` at OBSERVE cycle 3 on the first attempt only. Expect a retry with code 10 latched, then `o_pass`=1, `o_retry_cnt`=1.
4. **Sync loss and BER bad together.** Drop `i_ber_ok_i` and `i_sync_done_i` in the same cycle. Expect code 10, since sync loss has priority.
5. **Abort and restart.** Assert `i_abort` in WAIT_SYNC. Expect IDLE next cycle with all flags clear. Ignore a start pulse while busy. A new start after IDLE runs normally.
6. **Reset mid-OBSERVE.** Assert `i_reset`=0 for 1 cycle. Expect reset values on that edge, then `o_sys_rst_n`=1 in IDLE.
